div_result_checker: RTL
=======================

Name: div_result_checker

Overview:
- Sequential inverse of the team's sequential_divider.
- Takes the dividend and divisor sent to the divider, plus the divider's quotient, remainder and error outputs.
- Rebuilds dividend' = quotient*divisor + remainder with a shift-add multiplier, one bit per cycle.
- Reports a pass/fail verdict with a reason code. Sits beside the divider as an in-system self-check and as a bench scoreboard.

Parameters:
WIDTH, 8, operand width of dividend/divisor/quotient/remainder

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a check; sampled only in IDLE
dividend  input  WIDTH  original dividend
divisor  input  WIDTH  original divisor
quotient  input  WIDTH  divider quotient under test
remainder  input  WIDTH  divider remainder under test
div_error  input  1  divider error flag under test
recon  output  2*WIDTH  reconstructed quotient*divisor+remainder
done  output  1  one-cycle pulse: verdict valid
pass  output  1  check passed; held until next accepted start
fail  output  1  check failed; held until next accepted start
fail_code  output  3  bit0 value mismatch, bit1 remainder>=divisor, bit2 error-flag mismatch

Behaviour:
- Clock and reset:
  - Single clock (clk). Reset is synchronous and active-high (reset).
  - Reset forces: state IDLE; recon=0, done=0, pass=0, fail=0, fail_code=0; internal registers and counter cleared.
  - Reset in any state, including mid-MULT, aborts the check. No done is produced for the aborted request.
- States and transitions:
  - IDLE: start=1 latches all six inputs, clears pass/fail/fail_code/recon, then goes to CHECK. Otherwise stays in IDLE.
  - CHECK, divisor==0: fail_code={~div_error,0,0}, recon=0, next state DONE.
  - CHECK, divisor!=0: fail_code[2]=div_error; fail_code[1]=(remainder>=divisor); accumulator=0; counter=0; next state MULT.
  - MULT, 8 cycles for WIDTH=8 (counter 0..WIDTH-1):
    - If quotient bit[counter]=1, accumulator += divisor<<counter.
    - Counter increments. Leave after counter==WIDTH-1.
  - COMPARE: recon=accumulator+remainder (2*WIDTH bits, no overflow possible); fail_code[0]=(recon!=zero-extended dividend); next state DONE.
  - DONE: done=1 for exactly this cycle; pass=(fail_code==0); fail=~pass; next state IDLE.
- Latency, with start sampled at cycle 0:
  - Normal check: done at cycle WIDTH+3 (11 for WIDTH=8).
  - Divide-by-zero: done at cycle 2.
- Handshake rules:
  - start while not in IDLE is ignored and is not queued.
  - start held high continuously triggers back-to-back checks, re-sampled on each IDLE cycle.
  - Inputs need only be valid in the cycle start is accepted.
- Boundary conditions:
  - quotient=0: recon=remainder.
  - All-ones operands (255, 255, 255): recon=65280 with no wrap.
  - pass and fail are never both 1. Both are 0 from reset until the first DONE.

Decomposition:
- Shared package div_pkg holds:
  - State encoding constants (IDLE, CHECK, MULT, COMPARE, DONE).
  - fail_code bit-index constants (FC_VALUE=0, FC_REM=1, FC_ERR=2).
- No sub-module. Optionally factor out one sub-module, shift_add_step: combinational accumulator update for a single bit, with inputs accumulator, divisor, quotient bit and index.

Test Plan:
- dividend=15, divisor=3, q=5, r=0, div_error=0 -> done at cycle 11; recon=15; pass=1; fail_code=000.
- dividend=255, divisor=8, q=30, r=7 -> recon=247; fail=1; fail_code=001.
- dividend=255, divisor=8, q=30, r=15 -> recon=255; fail=1; fail_code=010.
- divisor=0 with div_error=1 -> done at cycle 2, pass=1. Repeat with div_error=0 -> fail=1, fail_code=100. Also divisor=6, div_error=1, correct q/r (20/6: 3, 2) -> fail_code=100.
- dividend=255, divisor=255, q=1, r=0 -> recon=255, pass. Then q=255, r=255 -> recon=65280, fail_code=011.
- Two interrupt cases on 20/6 (q=3, r=2):
  - Assert reset at MULT cycle 4 -> next cycle all outputs 0, state IDLE, no done. A fresh start then passes.
  - Pulse start at cycle 5 of a running check -> ignored; exactly one done.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and fail_code bit indices for div_result_checker
package div_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, MULT, COMPARE, DONE} state_t;
  localparam int FC_VALUE = 0;
  localparam int FC_REM   = 1;
  localparam int FC_ERR   = 2;
endpackage

// File: rtl/div_result_checker.sv
// div_result_checker: rebuilds quotient*divisor+remainder by shift-add and grades a divider result
// Ports: clk/reset (sync, active-high); start + dividend/divisor/quotient/remainder/div_error in;
// recon (2*WIDTH reconstruction), done (1-cycle verdict pulse), pass/fail (held), fail_code out.
module div_result_checker
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  input  logic               div_error,
  output logic [2*WIDTH-1:0] recon,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [2:0]         fail_code
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_dvd, r_dvs, r_q, r_r;
  logic               r_err, r_pass, r_fail;
  logic [2*WIDTH-1:0] r_acc, r_recon, w_step, w_recon;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_fc;
  logic               w_mismatch;
  assign w_step     = r_acc + (r_q[r_cnt] ? ({{WIDTH{1'b0}}, r_dvs} << r_cnt) : '0);
  assign w_recon    = r_acc + {{WIDTH{1'b0}}, r_r};
  assign w_mismatch = w_recon != {{WIDTH{1'b0}}, r_dvd};
  assign recon      = r_recon;
  assign done       = r_state == DONE;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_code  = r_fc;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CHECK : IDLE;
      CHECK:   w_next = (r_dvs == '0) ? DONE : MULT;
      MULT:    w_next = (r_cnt == CW'(WIDTH - 1)) ? COMPARE : MULT;
      COMPARE: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // pass/fail are loaded on the edge entering DONE so they are valid alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_dvd, r_dvs, r_q, r_r, r_err} <= '0;
      {r_acc, r_recon, r_cnt, r_fc, r_pass, r_fail} <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          {r_dvd, r_dvs, r_q, r_r, r_err} <= {dividend, divisor, quotient, remainder, div_error};
          {r_recon, r_fc, r_pass, r_fail} <= '0;
        end
        CHECK: if (r_dvs == '0) begin
          r_fc    <= {~r_err, 2'b00};
          r_recon <= '0;
          r_pass  <= r_err;
          r_fail  <= ~r_err;
        end else begin
          r_fc[FC_ERR] <= r_err;
          r_fc[FC_REM] <= r_r >= r_dvs;
          r_acc        <= '0;
          r_cnt        <= '0;
        end
        MULT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        COMPARE: begin
          r_recon        <= w_recon;
          r_fc[FC_VALUE] <= w_mismatch;
          r_pass         <= (r_fc[FC_ERR:FC_REM] == 2'b00) && !w_mismatch;
          r_fail         <= (r_fc[FC_ERR:FC_REM] != 2'b00) || w_mismatch;
        end
        default: ;
      endcase
    end
  end
endmodule
